// File: rtl/uart_debug_bridge_pkg.sv
// Shared constants for the UART debug bridge: command byte fields, ACK byte, FSM encodings.
// Optional feature macro used by the top: UART_DEBUG_WRITE_ACK_EN (write acknowledge byte).
package uart_debug_bridge_pkg;

  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_RSV_HI  = 6;
  localparam int CMD_RSV_LO  = 3;
  localparam int CMD_ADDR_HI = 2;
  localparam int CMD_ADDR_LO = 0;

  localparam logic [7:0] ACK_BYTE = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_DATA = 3'd1,
    ST_SETUP    = 3'd2,
    ST_STROBE   = 3'd3,
    ST_HOLD     = 3'd4,
    ST_TX_WAIT  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // A command is malformed when any reserved bit is set.
  function automatic logic cmd_is_bad(input logic [7:0] i_cmd);
    return i_cmd[CMD_RSV_HI:CMD_RSV_LO] != 4'b0000;
  endfunction

endpackage

// File: rtl/uart_debug_bridge_rx.sv
// uart_rx_deserializer: 8N1 receiver with 2-flop synchroniser, mid-bit sampling,
// false-start rejection and framing-error flag. Emits one-cycle byte/error pulses.
module uart_rx_deserializer
  import uart_debug_bridge_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_vld,
  output logic [7:0] o_byte,
  output logic       o_ferr
);

  localparam int                CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF  = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(CLK_DIV - 1);

  logic             r_sync0, r_sync1, r_sync2;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_vld, r_ferr;
  logic             w_fall;

  assign w_fall = r_sync2 & ~r_sync1;
  assign o_vld  = r_vld;
  assign o_ferr = r_ferr;
  assign o_byte = r_shift;

  // Bring the asynchronous line into the clock domain; r_sync2 is kept for edge detection.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync0 <= i_rx;
      r_sync1 <= r_sync0;
      r_sync2 <= r_sync1;
    end
  end

  // Frame sequencer: verify start at half bit, sample data at bit centres, check stop bit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_vld   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_vld  <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (w_fall) r_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt == HALF) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_sync1 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL) begin
            r_cnt   <= '0;
            r_shift <= {r_sync1, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= RX_STOP;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL) begin
            r_cnt   <= '0;
            r_vld   <= r_sync1;
            r_ferr  <= ~r_sync1;
            r_state <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_debug_bridge.sv
// uart_debug_bridge: serial command stream -> core debug port read/write cycles,
// read data returned over UART TX. Define UART_DEBUG_WRITE_ACK_EN to send 0x06 after each write.
module uart_debug_bridge
  import uart_debug_bridge_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       UART_RX,
  output logic       UART_TX,
  output logic [7:0] DEBUG_DIN,
  input  logic [7:0] DEBUG_DOUT,
  output logic [2:0] DEBUG_ADDR,
  output logic       DEBUG_RDN,
  output logic       DEBUG_WRN,
  output logic       BUSY,
  output logic       ERR
);

`ifdef UART_DEBUG_WRITE_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  localparam int                CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(CLK_DIV - 1);

  logic       w_rx_vld, w_rx_ferr;
  logic [7:0] w_rx_byte;
  logic       w_consume, w_overrun, w_bad_cmd, w_tx_load;
  logic [7:0] w_tx_byte;

  logic [7:0] r_hold;
  logic       r_hold_vld;
  state_t     r_state;
  logic       r_is_read;
  logic [2:0] r_cmd_addr;
  logic       r_strobe_cnt;
  logic [7:0] r_rd_data;
  logic [2:0] r_addr;
  logic [7:0] r_din;
  logic       r_rdn, r_wrn;
  logic       r_err;
  logic       r_tx;
  logic [8:0] r_tx_shift;
  logic       r_tx_active;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [3:0] r_tx_bit;

  uart_rx_deserializer #(.CLK_DIV(CLK_DIV)) u_rx (
    .i_clk   (CLK),
    .i_rst_n (RESETN),
    .i_rx    (UART_RX),
    .o_vld   (w_rx_vld),
    .o_byte  (w_rx_byte),
    .o_ferr  (w_rx_ferr)
  );

  // The FSM only takes bytes while waiting for a command or a write's data byte.
  assign w_consume = r_hold_vld && (r_state == ST_IDLE || r_state == ST_GET_DATA);
  assign w_overrun = w_rx_vld && r_hold_vld && !w_consume;
  assign w_bad_cmd = (r_state == ST_IDLE) && r_hold_vld && cmd_is_bad(r_hold);
  assign w_tx_load = (r_state == ST_HOLD) && (r_is_read || ACK_EN);
  assign w_tx_byte = r_is_read ? r_rd_data : ACK_BYTE;

  assign UART_TX    = r_tx;
  assign DEBUG_DIN  = r_din;
  assign DEBUG_ADDR = r_addr;
  assign DEBUG_RDN  = r_rdn;
  assign DEBUG_WRN  = r_wrn;
  assign BUSY       = (r_state != ST_IDLE) || r_tx_active;
  assign ERR        = r_err;

  // One-byte holding register; a byte arriving while it is still full is dropped.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_hold_vld <= 1'b0;
    end else if (w_rx_vld && (!r_hold_vld || w_consume)) begin
      r_hold     <= w_rx_byte;
      r_hold_vld <= 1'b1;
    end else if (w_consume) begin
      r_hold_vld <= 1'b0;
    end
  end

  // Merge all error sources into a single registered pulse.
  always_ff @(posedge CLK) begin
    if (!RESETN) r_err <= 1'b0;
    else         r_err <= w_rx_ferr | w_overrun | w_bad_cmd;
  end

  // Command FSM: decode, drive address/data, time the strobe, capture read data.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state      <= ST_IDLE;
      r_is_read    <= 1'b0;
      r_cmd_addr   <= '0;
      r_strobe_cnt <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
      r_rdn        <= 1'b1;
      r_wrn        <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_hold_vld && !cmd_is_bad(r_hold)) begin
            r_is_read  <= ~r_hold[CMD_WR_BIT];
            r_cmd_addr <= r_hold[CMD_ADDR_HI:CMD_ADDR_LO];
            if (r_hold[CMD_WR_BIT]) begin
              r_state <= ST_GET_DATA;
            end else begin
              r_addr  <= r_hold[CMD_ADDR_HI:CMD_ADDR_LO];
              r_state <= ST_SETUP;
            end
          end
        end
        ST_GET_DATA: begin
          if (r_hold_vld) begin
            r_addr  <= r_cmd_addr;
            r_din   <= r_hold;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_strobe_cnt <= 1'b0;
          r_rdn        <= ~r_is_read;
          r_wrn        <= r_is_read;
          r_state      <= ST_STROBE;
        end
        ST_STROBE: begin
          if (r_strobe_cnt) begin
            r_rdn   <= 1'b1;
            r_wrn   <= 1'b1;
            if (r_is_read) r_rd_data <= DEBUG_DOUT;
            r_state <= ST_HOLD;
          end else begin
            r_strobe_cnt <= 1'b1;
          end
        end
        ST_HOLD: begin
          r_state <= (r_is_read || ACK_EN) ? ST_TX_WAIT : ST_IDLE;
        end
        ST_TX_WAIT: begin
          if (!r_tx_active) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // TX shifter: start bit on load, then 8 data bits LSB first and one stop bit.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_tx        <= 1'b1;
      r_tx_active <= 1'b0;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
    end else if (w_tx_load) begin
      r_tx        <= 1'b0;
      r_tx_shift  <= {1'b1, w_tx_byte};
      r_tx_active <= 1'b1;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
    end else if (r_tx_active) begin
      if (r_tx_cnt == FULL) begin
        r_tx_cnt <= '0;
        if (r_tx_bit == 4'd9) begin
          r_tx_active <= 1'b0;
        end else begin
          r_tx       <= r_tx_shift[0];
          r_tx_shift <= {1'b1, r_tx_shift[8:1]};
          r_tx_bit   <= r_tx_bit + 1'b1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_debug_bridge.sv
// Directed bench for uart_debug_bridge at CLK_DIV=4.
module tb_uart_debug_bridge;

  localparam int CLK_DIV = 4;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       UART_RX;
  logic       UART_TX;
  logic [7:0] DEBUG_DIN;
  logic [7:0] DEBUG_DOUT;
  logic [2:0] DEBUG_ADDR;
  logic       DEBUG_RDN;
  logic       DEBUG_WRN;
  logic       BUSY;
  logic       ERR;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state (written only by the monitor processes).
  int         wrn_run = 0, wrn_pulses = 0, wrn_width = 0;
  logic [2:0] wrn_addr = '0;
  logic [7:0] wrn_din = '0;
  int         rdn_run = 0, rdn_pulses = 0, rdn_width = 0;
  logic [2:0] rdn_addr = '0;
  int         err_cnt = 0, busy_cnt = 0;
  int         tx_cnt = 0, tx_bad = 0;
  logic [7:0] tx_last = '0;

  uart_debug_bridge #(.CLK_DIV(CLK_DIV)) dut (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .UART_RX    (UART_RX),
    .UART_TX    (UART_TX),
    .DEBUG_DIN  (DEBUG_DIN),
    .DEBUG_DOUT (DEBUG_DOUT),
    .DEBUG_ADDR (DEBUG_ADDR),
    .DEBUG_RDN  (DEBUG_RDN),
    .DEBUG_WRN  (DEBUG_WRN),
    .BUSY       (BUSY),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  // Strobe, error and busy monitor sampled on the falling edge.
  always @(negedge CLK) begin
    if (DEBUG_WRN === 1'b0) begin
      wrn_run  = wrn_run + 1;
      wrn_addr = DEBUG_ADDR;
      wrn_din  = DEBUG_DIN;
    end else if (wrn_run != 0) begin
      wrn_pulses = wrn_pulses + 1;
      wrn_width  = wrn_run;
      wrn_run    = 0;
    end
    if (DEBUG_RDN === 1'b0) begin
      rdn_run  = rdn_run + 1;
      rdn_addr = DEBUG_ADDR;
    end else if (rdn_run != 0) begin
      rdn_pulses = rdn_pulses + 1;
      rdn_width  = rdn_run;
      rdn_run    = 0;
    end
    if (ERR === 1'b1)  err_cnt  = err_cnt + 1;
    if (BUSY === 1'b1) busy_cnt = busy_cnt + 1;
  end

  // UART TX decoder: samples mid-bit, records each completed frame.
  always begin
    logic [7:0] b;
    @(negedge UART_TX);
    if (RESETN === 1'b1) begin
      repeat (CLK_DIV / 2) @(posedge CLK);
      #1;
      if (UART_TX !== 1'b0) tx_bad = tx_bad + 1;
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(posedge CLK);
        #1;
        b[i] = UART_TX;
      end
      repeat (CLK_DIV) @(posedge CLK);
      #1;
      if (UART_TX !== 1'b1) tx_bad = tx_bad + 1;
      tx_last = b;
      tx_cnt  = tx_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    @(posedge CLK); #1;
    UART_RX = 1'b0;
    repeat (CLK_DIV) @(posedge CLK);
    #1;
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (CLK_DIV) @(posedge CLK);
      #1;
    end
    UART_RX = stop_bit;
    repeat (CLK_DIV - 1) @(posedge CLK);
    #1;
    UART_RX = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    int w0, r0, e0, t0, b0;
    int dr, de;
    logic found;

    RESETN     = 1'b0;
    UART_RX    = 1'b1;
    DEBUG_DOUT = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_uart_tx", 32'(UART_TX), 32'd1);
    check("rst_rdn",     32'(DEBUG_RDN), 32'd1);
    check("rst_wrn",     32'(DEBUG_WRN), 32'd1);
    check("rst_busy",    32'(BUSY), 32'd0);
    check("rst_err",     32'(ERR), 32'd0);
    check("rst_addr",    32'(DEBUG_ADDR), 32'd0);
    check("rst_din",     32'(DEBUG_DIN), 32'd0);
    RESETN = 1'b1;
    wait_cycles(10);

    // Write 0x3C to address 5.
    w0 = wrn_pulses; r0 = rdn_pulses; e0 = err_cnt; t0 = tx_cnt;
    uart_send(8'h85, 1'b1);
    uart_send(8'h3C, 1'b1);
    wait_cycles(70);
    check("wr_pulses",  32'(wrn_pulses - w0), 32'd1);
    check("wr_width",   32'(wrn_width), 32'd2);
    check("wr_addr",    32'(wrn_addr), 32'd5);
    check("wr_din",     32'(wrn_din), 32'h3C);
    check("wr_no_rd",   32'(rdn_pulses - r0), 32'd0);
    check("wr_no_err",  32'(err_cnt - e0), 32'd0);
    check("wr_addr_hold", 32'(DEBUG_ADDR), 32'd5);
    check("wr_din_hold",  32'(DEBUG_DIN), 32'h3C);
    check("wr_idle",    32'(BUSY), 32'd0);
`ifdef UART_DEBUG_WRITE_ACK_EN
    check("wr_ack_cnt",  32'(tx_cnt - t0), 32'd1);
    check("wr_ack_byte", 32'(tx_last), 32'h06);
`else
    check("wr_no_tx",    32'(tx_cnt - t0), 32'd0);
`endif

    // Read address 2, core returns 0xA7.
    DEBUG_DOUT = 8'hA7;
    w0 = wrn_pulses; r0 = rdn_pulses; e0 = err_cnt; t0 = tx_cnt;
    uart_send(8'h02, 1'b1);
    wait_cycles(70);
    check("rd_pulses",  32'(rdn_pulses - r0), 32'd1);
    check("rd_width",   32'(rdn_width), 32'd2);
    check("rd_addr",    32'(rdn_addr), 32'd2);
    check("rd_tx_cnt",  32'(tx_cnt - t0), 32'd1);
    check("rd_tx_byte", 32'(tx_last), 32'hA7);
    check("rd_no_wr",   32'(wrn_pulses - w0), 32'd0);
    check("rd_no_err",  32'(err_cnt - e0), 32'd0);

    // Bad command: reserved bits set.
    w0 = wrn_pulses; r0 = rdn_pulses; e0 = err_cnt; b0 = busy_cnt;
    uart_send(8'h48, 1'b1);
    wait_cycles(20);
    check("bad_err",    32'(err_cnt - e0), 32'd1);
    check("bad_no_rd",  32'(rdn_pulses - r0), 32'd0);
    check("bad_no_wr",  32'(wrn_pulses - w0), 32'd0);
    check("bad_busy",   32'(busy_cnt - b0), 32'd0);

    // Framing error: read command with stop bit 0.
    r0 = rdn_pulses; e0 = err_cnt; t0 = tx_cnt;
    uart_send(8'h02, 1'b0);
    wait_cycles(30);
    check("ferr_err",   32'(err_cnt - e0), 32'd1);
    check("ferr_no_rd", 32'(rdn_pulses - r0), 32'd0);
    check("ferr_no_tx", 32'(tx_cnt - t0), 32'd0);

    // One-cycle glitch is a false start: silently ignored.
    r0 = rdn_pulses; e0 = err_cnt;
    @(posedge CLK); #1; UART_RX = 1'b0;
    @(posedge CLK); #1; UART_RX = 1'b1;
    wait_cycles(30);
    check("glitch_no_err", 32'(err_cnt - e0), 32'd0);
    check("glitch_no_rd",  32'(rdn_pulses - r0), 32'd0);

    // Back-to-back reads outpace the read+TX turnaround: held bytes are
    // executed, a byte arriving while the holding register is full is dropped.
    DEBUG_DOUT = 8'h5A;
    w0 = wrn_pulses; r0 = rdn_pulses; e0 = err_cnt; t0 = tx_cnt;
    for (int k = 0; k < 12; k++) uart_send(8'h01, 1'b1);
    wait_cycles(250);
    dr = rdn_pulses - r0;
    de = err_cnt - e0;
    check("ovr_err_seen",  32'(de != 0), 32'd1);
    check("ovr_accounted", 32'(dr + de), 32'd12);
    check("ovr_tx_cnt",    32'(tx_cnt - t0), 32'(dr));
    check("ovr_tx_byte",   32'(tx_last), 32'h5A);
    check("ovr_rd_addr",   32'(rdn_addr), 32'd1);
    check("ovr_no_wr",     32'(wrn_pulses - w0), 32'd0);
    check("tx_frames_ok",  32'(tx_bad), 32'd0);

    // Reset asserted during a write strobe.
    uart_send(8'h81, 1'b1);
    uart_send(8'h11, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (DEBUG_WRN === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check("rs_strobe_seen", 32'(found), 32'd1);
    RESETN = 1'b0;
    @(posedge CLK); #1;
    check("rs_wrn_high", 32'(DEBUG_WRN), 32'd1);
    check("rs_busy",     32'(BUSY), 32'd0);
    check("rs_addr",     32'(DEBUG_ADDR), 32'd0);
    wait_cycles(2);
    RESETN = 1'b1;
    t0 = tx_cnt;
    wait_cycles(60);
    check("rs_no_tx",    32'(tx_cnt - t0), 32'd0);
    check("rs_tx_idle",  32'(UART_TX), 32'd1);
    check("rs_idle",     32'(BUSY), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
